cacheline_adaptor: RTL and testbench
====================================

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: line_read_i  in  1  line read request from the L2/arbiter side, held until line_resp_o.
REQ-004 SHALL have: line_write_i  in  1  line write request from the L2/arbiter side, held until line_resp_o.
REQ-005 SHALL have: line_address_i  in  32  byte address of the line.
REQ-006 SHALL have: line_wdata_i  in  256  line to write.
REQ-007 SHALL have: line_rdata_o  out  256  assembled read line.
REQ-008 SHALL have: line_resp_o  out  1  one-cycle completion pulse.
REQ-009 SHALL have: burst_read_o  out  1  memory read request.
REQ-010 SHALL have: burst_write_o  out  1  memory write request.
REQ-011 SHALL have: burst_address_o  out  32  latched address, bits [4:0] forced to 0.
REQ-012 SHALL have: burst_wdata_o  out  64  current write beat.
REQ-013 SHALL have: burst_rdata_i  in  64  read beat, valid when burst_resp_i=1.
REQ-014 SHALL have: burst_resp_i  in  1  beat accept/valid strobe from memory.

Function
REQ-015 States SHALL be IDLE, READ, WRITE, DONE; a 2-bit beat counter SHALL index beats 0..3.
REQ-016 In IDLE, line_read_i=1 SHALL latch line_address_i, clear the counter and enter READ at the next edge.
REQ-017 In IDLE, line_write_i=1 with line_read_i=0 SHALL latch the address and line_wdata_i, clear the counter and enter WRITE.
REQ-018 Read and write asserted together SHALL be treated as a read; the write is ignored.
REQ-019 burst_read_o SHALL be 1 exactly while in READ; burst_write_o SHALL be 1 exactly while in WRITE; both are decoded from state only.
REQ-020 In READ, each cycle with burst_resp_i=1 SHALL store burst_rdata_i into line bits [64k+63:64k], where k is the counter, then increment k.
REQ-021 In WRITE, burst_wdata_o SHALL equal latched wdata bits [64k+63:64k]; k SHALL increment on each burst_resp_i=1.
REQ-022 Beats need not be consecutive; cycles with burst_resp_i=0 SHALL hold k and the data.
REQ-023 The beat accepted at k=3 SHALL move the FSM to DONE at the next edge; k wraps to 0.
REQ-024 DONE SHALL assert line_resp_o for exactly one cycle, then return to IDLE.
REQ-025 line_rdata_o SHALL hold the last assembled line until the next read completes.
REQ-026 Minimum read or write latency SHALL be 6 cycles, from request sampled to line_resp_o, with 4 back-to-back beats.
REQ-027 Upstream SHALL drop its request in the cycle after line_resp_o; a request still high in IDLE starts a new transaction.
REQ-028 burst_resp_i in IDLE or DONE SHALL be ignored.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, k=0, line_rdata_o=0 and the latched address/wdata to 0, including mid-burst.
REQ-030 From the cycle after reset, all outputs SHALL be 0 (line_resp_o, burst_read_o, burst_write_o, burst_address_o, burst_wdata_o, line_rdata_o); partial beats are discarded.

Configuration
REQ-031 When CACHELINE_ADAPTOR_LINE_REUSE_EN is defined, the block SHALL keep a valid bit and tag (address[31:5]) for the last completed read line.
REQ-032 With CACHELINE_ADAPTOR_LINE_REUSE_EN defined, a read in IDLE whose tag matches a valid entry SHALL go directly to DONE with no burst and a 2-cycle latency.
REQ-033 With CACHELINE_ADAPTOR_LINE_REUSE_EN defined, a write whose tag matches SHALL clear the valid bit when the write is accepted, and reset SHALL clear the valid bit.
REQ-034 With CACHELINE_ADAPTOR_LINE_REUSE_EN undefined, every read SHALL perform a full burst and no reuse storage SHALL exist.

Verification
REQ-035 The bench SHALL cover: read at 0x0000_1234, beats 0x11..,0x22..,0x33..,0x44.. back-to-back -> burst_address_o=0x0000_1220, line_rdata_o={0x44..,0x33..,0x22..,0x11..}, line_resp_o one pulse at cycle 6.
REQ-036 The bench SHALL cover: write of 256'hDDDD..CCCC..BBBB..AAAA.. -> burst_wdata_o beats AAAA,BBBB,CCCC,DDDD in order, burst_write_o high exactly 4 resp cycles.
REQ-037 The bench SHALL cover: read with burst_resp_i gaps (pattern 1,0,0,1,1,0,1) -> identical line, resp after the 4th beat only.
REQ-038 The bench SHALL cover: rst pulse after 2 read beats -> IDLE, burst_read_o=0 and line_rdata_o=0 next cycle, no line_resp_o.
REQ-039 The bench SHALL cover: read and write both high -> read burst only, burst_write_o never asserted.
REQ-040 The bench SHALL cover, with CACHELINE_ADAPTOR_LINE_REUSE_EN: repeat read of 0x1220 -> resp at cycle 2 with no burst_read_o; write to 0x1220 then read -> full burst.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: 256-bit line <-> four 64-bit memory bursts.
// Optional: CACHELINE_ADAPTOR_LINE_REUSE_EN serves a repeat read of the last line.

module cacheline_adaptor (
    input  logic         clk,
    input  logic         rst,
    input  logic         line_read_i,
    input  logic         line_write_i,
    input  logic [31:0]  line_address_i,
    input  logic [255:0] line_wdata_i,
    output logic [255:0] line_rdata_o,
    output logic         line_resp_o,
    output logic         burst_read_o,
    output logic         burst_write_o,
    output logic [31:0]  burst_address_o,
    output logic [63:0]  burst_wdata_o,
    input  logic [63:0]  burst_rdata_i,
    input  logic         burst_resp_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state;
    logic [1:0]     beat;
    logic [31:0]    addr;
    logic [255:0]   wdata;
    logic [191:0]   rbuf;
    logic [255:0]   rdata;

`ifdef CACHELINE_ADAPTOR_LINE_REUSE_EN
    logic           valid;
    logic [26:0]    tag;
    logic           hit;

    assign hit = valid && (tag == line_address_i[31:5]);
`endif

    assign burst_read_o    = (state == READ);
    assign burst_write_o   = (state == WRITE);
    assign line_resp_o     = (state == DONE);
    assign burst_address_o = addr & ~32'h1f;
    assign burst_wdata_o   = wdata[{beat, 6'd0} +: 64];
    assign line_rdata_o    = rdata;

    // Transaction FSM: latch request, walk four beats, pulse completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            beat  <= 2'd0;
            addr  <= 32'd0;
            wdata <= 256'd0;
            rbuf  <= 192'd0;
            rdata <= 256'd0;
`ifdef CACHELINE_ADAPTOR_LINE_REUSE_EN
            valid <= 1'b0;
            tag   <= 27'd0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (line_read_i) begin
                        addr <= line_address_i;
                        beat <= 2'd0;
`ifdef CACHELINE_ADAPTOR_LINE_REUSE_EN
                        state <= hit ? DONE : READ;
`else
                        state <= READ;
`endif
                    end else if (line_write_i) begin
                        addr  <= line_address_i;
                        wdata <= line_wdata_i;
                        beat  <= 2'd0;
                        state <= WRITE;
`ifdef CACHELINE_ADAPTOR_LINE_REUSE_EN
                        if (hit) valid <= 1'b0;
`endif
                    end
                end
                READ: begin
                    if (burst_resp_i) begin
                        beat <= beat + 2'd1;
                        unique case (beat)
                            2'd0: rbuf[63:0]    <= burst_rdata_i;
                            2'd1: rbuf[127:64]  <= burst_rdata_i;
                            2'd2: rbuf[191:128] <= burst_rdata_i;
                            2'd3: begin
                                rdata <= {burst_rdata_i, rbuf};
                                state <= DONE;
`ifdef CACHELINE_ADAPTOR_LINE_REUSE_EN
                                valid <= 1'b1;
                                tag   <= addr[31:5];
`endif
                            end
                        endcase
                    end
                end
                WRITE: begin
                    if (burst_resp_i) begin
                        beat <= beat + 2'd1;
                        if (beat == 2'd3) state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: directed and random line transactions
// against a line-level memory/reuse model.

module tb_cacheline_adaptor;

`ifdef CACHELINE_ADAPTOR_LINE_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         line_read_i = 1'b0;
    logic         line_write_i = 1'b0;
    logic [31:0]  line_address_i = 32'd0;
    logic [255:0] line_wdata_i = 256'd0;
    logic [255:0] line_rdata_o;
    logic         line_resp_o;
    logic         burst_read_o;
    logic         burst_write_o;
    logic [31:0]  burst_address_o;
    logic [63:0]  burst_wdata_o;
    logic [63:0]  burst_rdata_i = 64'd0;
    logic         burst_resp_i = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    logic [255:0] m_line = 256'd0;
    bit           m_valid = 1'b0;
    logic [26:0]  m_tag = 27'd0;

    cacheline_adaptor dut (
        .clk             (clk),
        .rst             (rst),
        .line_read_i     (line_read_i),
        .line_write_i    (line_write_i),
        .line_address_i  (line_address_i),
        .line_wdata_i    (line_wdata_i),
        .line_rdata_o    (line_rdata_o),
        .line_resp_o     (line_resp_o),
        .burst_read_o    (burst_read_o),
        .burst_write_o   (burst_write_o),
        .burst_address_o (burst_address_o),
        .burst_wdata_o   (burst_wdata_o),
        .burst_rdata_i   (burst_rdata_i),
        .burst_resp_i    (burst_resp_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic bit pick(input int mode, input int n);
        bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        if (mode == 0) return 1'b1;
        if (mode == 1) return pat[(n - 1) % 7];
        return $urandom_range(0, 2) != 0;
    endfunction

    // One line transaction; rd wins when both rd and wr are set.
    task automatic txn(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [255:0] line, input int mode);
        bit           is_rd = rd;
        bit           hit;
        bit           done = 1'b0;
        bit           r;
        int           cyc = 1;
        int           act_n = 0;
        int           other_n = 0;
        int           beats = 0;
        int           last_cyc = -100;
        logic [255:0] exp_line;
        hit = REUSE && is_rd && m_valid && (m_tag == a[31:5]);
        exp_line = (is_rd && !hit) ? line : m_line;
        line_read_i    = rd;
        line_write_i   = wr;
        line_address_i = a;
        line_wdata_i   = (!rd && wr) ? line : rand_line();
        burst_resp_i   = $urandom_range(0, 1);
        burst_rdata_i  = {$urandom, $urandom};
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (is_rd ? burst_write_o : burst_read_o) other_n++;
            if (is_rd ? burst_read_o : burst_write_o) begin
                act_n++;
                if (act_n == 1) chk("first_burst_cycle", cyc, 2);
                chk("burst_address", burst_address_o, a & ~32'h1f);
                if (!is_rd && beats < 4)
                    chk("wbeat", burst_wdata_o, line[beats*64 +: 64]);
                r = pick(mode, act_n);
                burst_resp_i  = r;
                burst_rdata_i = (r && beats < 4) ? line[beats*64 +: 64]
                                                 : {$urandom, $urandom};
                if (r) begin
                    beats++;
                    if (beats == 4) last_cyc = cyc;
                end
            end else begin
                burst_resp_i  = $urandom_range(0, 1);
                burst_rdata_i = {$urandom, $urandom};
            end
            if (line_resp_o) begin
                done = 1'b1;
                line_read_i  = 1'b0;
                line_write_i = 1'b0;
                chk("line_rdata", line_rdata_o, exp_line);
            end
        end
        chk("resp_seen", done, 1'b1);
        chk("beats", beats, hit ? 0 : 4);
        chk("resp_cycle", cyc, hit ? 2 : last_cyc + 1);
        chk("other_burst", other_n, 0);
        if (mode == 0 && !hit) chk("burst_cycles", act_n, 4);
        if (hit) chk("hit_burst_cycles", act_n, 0);
        line_read_i  = 1'b0;
        line_write_i = 1'b0;
        @(negedge clk);
        chk("resp_pulse_end", line_resp_o, 1'b0);
        chk("idle_no_read", burst_read_o, 1'b0);
        if (is_rd && !hit) begin
            m_line  = line;
            m_valid = 1'b1;
            m_tag   = a[31:5];
        end else if (!is_rd && m_tag == a[31:5]) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic reset_mid_read(input logic [31:0] a,
                                  input logic [255:0] line);
        int  beats = 0;
        bit  fired = 1'b0;
        line_read_i    = 1'b1;
        line_address_i = a;
        burst_resp_i   = 1'b0;
        for (int c = 0; c < 20 && !fired; c++) begin
            @(negedge clk);
            if (burst_read_o && beats < 2) begin
                burst_resp_i  = 1'b1;
                burst_rdata_i = line[beats*64 +: 64];
                beats++;
            end else if (burst_read_o) begin
                rst          = 1'b1;
                line_read_i  = 1'b0;
                burst_resp_i = 1'b0;
                fired        = 1'b1;
            end
        end
        chk("rst_reached", fired, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_burst_read", burst_read_o, 1'b0);
        chk("rst_line_rdata", line_rdata_o, 256'd0);
        chk("rst_line_resp", line_resp_o, 1'b0);
        chk("rst_burst_addr", burst_address_o, 32'd0);
        m_line  = 256'd0;
        m_valid = 1'b0;
        m_tag   = 27'd0;
        for (int c = 0; c < 3; c++) begin
            burst_resp_i = 1'b1;
            @(negedge clk);
            chk("post_rst_resp", line_resp_o, 1'b0);
            chk("post_rst_read", burst_read_o, 1'b0);
        end
        burst_resp_i = 1'b0;
    endtask

    initial begin
        logic [255:0] l1;
        logic [255:0] lw;
        logic [31:0]  a;
        int           kind;
        l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        lw = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        @(negedge clk);
        @(negedge clk);
        chk("reset_line_resp", line_resp_o, 1'b0);
        chk("reset_burst_read", burst_read_o, 1'b0);
        chk("reset_burst_write", burst_write_o, 1'b0);
        chk("reset_burst_addr", burst_address_o, 32'd0);
        chk("reset_burst_wdata", burst_wdata_o, 64'd0);
        chk("reset_line_rdata", line_rdata_o, 256'd0);
        rst = 1'b0;
        @(negedge clk);

        txn(1'b1, 1'b0, 32'h0000_1234, l1, 0);
        txn(1'b1, 1'b0, 32'h0000_1220, l1, 0);
        txn(1'b0, 1'b1, 32'h0000_1220, lw, 0);
        txn(1'b1, 1'b0, 32'h0000_1220, l1, 1);
        txn(1'b1, 1'b1, 32'h0000_5678, rand_line(), 0);
        reset_mid_read(32'h0000_9000, rand_line());

        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 3);
            a = 32'h0000_2000 + ($urandom_range(0, 3) << 5)
                + $urandom_range(0, 31);
            txn(kind != 2, kind >= 2, a, rand_line(),
                $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
